key_scan_entry: RTL and testbench

//  Scans a 4x4 active-low key matrix, debounces it, and decodes each press.

---
 rtl/key_scan_pkg.sv | 48 ++++
 rtl/scan_tick_gen.sv | 24 ++
 rtl/key_scan_entry.sv | 164 ++++++++++++++++
 tb/tb_key_scan_entry.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared types and constants for the 4x4 key matrix front end.
package key_scan_pkg;

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PRESS,
    S_RELEASE
  } state_t;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;  // clear
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;  // backspace
  localparam logic [3:0] KEY_HASH = 4'hF;  // display enable toggle

  // Nibble the display driver renders as an unlit digit.
  localparam logic [3:0]  BLANK     = 4'hA;
  localparam logic [23:0] NUM_BLANK = {6{BLANK}};

  // Row/column index to key code.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_A;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_B;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = KEY_0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle scan strobe every SCAN_DIV clocks.
module scan_tick_gen #(
  parameter int SCAN_DIV = 50_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST);

  // Divider counts 0..SCAN_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (rst) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + 1'b1;
  end

endmodule

// File: rtl/key_scan_entry.sv
// Key matrix scanner, debouncer and digit-entry register for the board UI.
module key_scan_entry
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_col,
  output logic [3:0]  key_row,
  output logic [23:0] num,
  output logic        display_en,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  function automatic logic single_zero(input logic [3:0] v);
    logic [2:0] zeros;
    zeros = 3'(!v[0]) + 3'(!v[1]) + 3'(!v[2]) + 3'(!v[3]);
    return (zeros == 3'd1);
  endfunction

  // Position of the low bit in an active-low one-hot vector.
  function automatic logic [1:0] zero_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  logic          tick;
  logic [3:0]    col_p0, col_p1;
  logic [3:0]    cs;
  state_t        state, state_nxt;
  logic [3:0]    row_nxt;
  logic [3:0]    lat_col, lat_col_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    code_nxt;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Stage p0 -> p1: two-flop synchronizer on the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_p0 <= 4'hF;
      col_p1 <= 4'hF;
    end else begin
      col_p0 <= key_col;
      col_p1 <= col_p0;
    end
  end

  assign cs        = col_p1;
  assign cnt_inc   = cnt + 1'b1;
  assign key_valid = (state == S_PRESS);

  // Control registers: state, row drive, latched column, debounce count, code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_SCAN;
      key_row  <= 4'b1110;
      lat_col  <= 4'hF;
      cnt      <= '0;
      key_code <= 4'h0;
    end else begin
      state    <= state_nxt;
      key_row  <= row_nxt;
      lat_col  <= lat_col_nxt;
      cnt      <= cnt_nxt;
      key_code <= code_nxt;
    end
  end

  // Next-state logic; everything but the press pulse advances only on tick.
  always_comb begin
    state_nxt   = state;
    row_nxt     = key_row;
    lat_col_nxt = lat_col;
    cnt_nxt     = cnt;
    code_nxt    = key_code;
    case (state)
      S_SCAN: begin
        if (tick) begin
          if (single_zero(cs)) begin
            lat_col_nxt = cs;
            cnt_nxt     = '0;
            state_nxt   = S_DEBOUNCE;
          end else begin
            // Idle or ghosted multi-key pattern: keep scanning.
            row_nxt = {key_row[2:0], key_row[3]};
          end
        end
      end
      S_DEBOUNCE: begin
        if (tick) begin
          if (cs == lat_col) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_nxt = S_PRESS;
              code_nxt  = key_map(zero_idx(key_row), zero_idx(lat_col));
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = S_SCAN;
          end
        end
      end
      S_PRESS: begin
        cnt_nxt   = '0;
        state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (tick) begin
          if (cs == 4'hF) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              cnt_nxt   = '0;
              state_nxt = S_SCAN;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = S_SCAN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Digit register and display enable, updated once per accepted press.
  always_ff @(posedge clk) begin
    if (rst) begin
      num        <= NUM_BLANK;
      display_en <= 1'b1;
    end else if (state == S_PRESS) begin
      if (key_code <= KEY_9) begin
        num <= {num[19:0], key_code};
      end else begin
        case (key_code)
          KEY_A:    num        <= NUM_BLANK;
          KEY_STAR: num        <= {BLANK, num[23:4]};
          KEY_HASH: display_en <= ~display_en;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_scan_entry.sv
// Directed bench for key_scan_entry with a small key matrix model.
module tb_key_scan_entry;

  localparam int SD = 8;
  localparam int DT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [23:0] num;
  logic        display_en;
  logic        key_valid;
  logic [3:0]  key_code;

  logic       ka_en = 1'b0, kb_en = 1'b0;
  logic [1:0] ka_r = 2'd0, ka_c = 2'd0, kb_r = 2'd0, kb_c = 2'd0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int wide = 0;
  int cyc = 0;
  int pulse_cyc = 0;
  logic [3:0] last_code = 4'h0;
  logic prev_kv = 1'b0;

  key_scan_entry #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_col    (key_col),
    .key_row    (key_row),
    .num        (num),
    .display_en (display_en),
    .key_valid  (key_valid),
    .key_code   (key_code)
  );

  always #5 clk = ~clk;

  // Matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    key_col = 4'hF;
    if (ka_en && !key_row[ka_r]) key_col[ka_c] = 1'b0;
    if (kb_en && !key_row[kb_r]) key_col[kb_c] = 1'b0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_kv <= 1'b0;
    end else begin
      prev_kv <= key_valid;
      if (key_valid) begin
        pulses    <= pulses + 1;
        last_code <= key_code;
        pulse_cyc <= cyc;
      end
      if (key_valid && prev_kv) wide <= wide + 1;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * SD) @(posedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c, input int hold, input int idle);
    ka_r = r; ka_c = c; ka_en = 1'b1;
    wait_ticks(hold);
    ka_en = 1'b0;
    wait_ticks(idle);
  endtask

  task automatic wait_pulse(input int base, input int max_clk);
    int n;
    n = 0;
    while (pulses == base && n < max_clk) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (key_row !== 4'b1110) begin errors++; $display("FAIL %s key_row: got %b want 1110", tag, key_row); end
    checks++;
    if (num !== 24'hAAAAAA) begin errors++; $display("FAIL %s num: got %h want aaaaaa", tag, num); end
    checks++;
    if (display_en !== 1'b1) begin errors++; $display("FAIL %s display_en: got %b want 1", tag, display_en); end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL %s key_valid: got %b want 0", tag, key_valid); end
    checks++;
    if (key_code !== 4'h0) begin errors++; $display("FAIL %s key_code: got %h want 0", tag, key_code); end
  endtask

  task automatic test_reset();
    logic [3:0] rows [4];
    rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do_reset();
    check_reset_vals("reset");
    for (int i = 1; i <= 10; i++) begin
      repeat (SD) @(posedge clk);
      #1;
      checks++;
      if (key_row !== rows[i % 4]) begin
        errors++; $display("FAIL idle_row%0d: got %b want %b", i, key_row, rows[i % 4]);
      end
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL idle_pulses: got %0d want 0", pulses); end
    checks++;
    if (num !== 24'hAAAAAA || display_en !== 1'b1) begin
      errors++; $display("FAIL idle_outputs: got num=%h en=%b want aaaaaa/1", num, display_en);
    end
  endtask

  task automatic test_digits();
    int base;
    base = pulses;
    press(2'd0, 2'd0, 8, 8);
    press(2'd0, 2'd1, 8, 8);
    press(2'd0, 2'd2, 8, 8);
    checks++;
    if (pulses !== base + 3) begin errors++; $display("FAIL digits_pulses: got %0d want %0d", pulses - base, 3); end
    checks++;
    if (num !== 24'hAAA123) begin errors++; $display("FAIL digits_num: got %h want aaa123", num); end
    checks++;
    if (last_code !== 4'h3) begin errors++; $display("FAIL digits_code: got %h want 3", last_code); end
  endtask

  task automatic test_edit();
    logic [1:0] rr [7];
    logic [1:0] cc [7];
    rr = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    cc = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    for (int i = 0; i < 7; i++) press(rr[i], cc[i], 8, 8);
    checks++;
    if (num !== 24'h234567) begin errors++; $display("FAIL shift_num: got %h want 234567", num); end
    press(2'd3, 2'd0, 8, 8);
    checks++;
    if (num !== 24'hA23456) begin errors++; $display("FAIL backspace_num: got %h want a23456", num); end
    press(2'd0, 2'd3, 8, 8);
    checks++;
    if (num !== 24'hAAAAAA) begin errors++; $display("FAIL clear_num: got %h want aaaaaa", num); end
    press(2'd3, 2'd0, 8, 8);
    checks++;
    if (num !== 24'hAAAAAA) begin errors++; $display("FAIL backspace_blank: got %h want aaaaaa", num); end
  endtask

  task automatic test_bounce();
    int base, t0;
    base = pulses;
    ka_r = 2'd1; ka_c = 2'd1;
    ka_en = 1'b1; wait_ticks(1);
    ka_en = 1'b0; wait_ticks(1);
    ka_en = 1'b1; wait_ticks(1);
    ka_en = 1'b0; wait_ticks(1);
    ka_en = 1'b1;
    t0 = cyc;
    wait_pulse(base, 2 + (DT + 4) * SD + 2);
    checks++;
    if (pulses !== base + 1) begin errors++; $display("FAIL bounce_pulse: got %0d want 1", pulses - base); end
    checks++;
    if (pulse_cyc - t0 > 2 + (DT + 4) * SD) begin
      errors++; $display("FAIL bounce_latency: got %0d clk want <= %0d", pulse_cyc - t0, 2 + (DT + 4) * SD);
    end
    wait_ticks(10);
    ka_en = 1'b0;
    wait_ticks(8);
    checks++;
    if (pulses !== base + 1) begin errors++; $display("FAIL bounce_count: got %0d want 1", pulses - base); end
    checks++;
    if (last_code !== 4'h5) begin errors++; $display("FAIL bounce_code: got %h want 5", last_code); end
    checks++;
    if (num !== 24'hAAAAA5) begin errors++; $display("FAIL bounce_num: got %h want aaaaa5", num); end
  endtask

  task automatic test_hash_multi();
    int base;
    base = pulses;
    press(2'd3, 2'd2, 50, 8);
    checks++;
    if (pulses !== base + 1) begin errors++; $display("FAIL hold_pulses: got %0d want 1", pulses - base); end
    checks++;
    if (display_en !== 1'b0) begin errors++; $display("FAIL hash_off: got %b want 0", display_en); end
    press(2'd3, 2'd2, 8, 8);
    checks++;
    if (display_en !== 1'b1) begin errors++; $display("FAIL hash_on: got %b want 1", display_en); end
    base = pulses;
    kb_r = 2'd1; kb_c = 2'd0; kb_en = 1'b1;
    press(2'd1, 2'd1, 12, 0);
    kb_en = 1'b0;
    wait_ticks(8);
    checks++;
    if (pulses !== base) begin errors++; $display("FAIL multikey_pulse: got %0d want 0", pulses - base); end
    checks++;
    if (num !== 24'hAAAAA5) begin errors++; $display("FAIL multikey_num: got %h want aaaaa5", num); end
  endtask

  task automatic test_reset_midop();
    int base, n;
    press(2'd2, 2'd2, 8, 8);
    press(2'd3, 2'd2, 8, 8);
    checks++;
    if (num !== 24'hAAAA59 || display_en !== 1'b0) begin
      errors++; $display("FAIL prep: got num=%h en=%b want aaaa59/0", num, display_en);
    end
    n = 0;
    while (key_row == 4'b1110 && n < 40) begin @(posedge clk); #1; n++; end
    n = 0;
    while (key_row != 4'b1110 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (key_row !== 4'b1110) begin errors++; $display("FAIL row_sync: got %b want 1110", key_row); end
    ka_r = 2'd0; ka_c = 2'd0; ka_en = 1'b1;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("rst_debounce");
    rst = 1'b0;
    base = pulses;
    wait_pulse(base, 12 * SD);
    checks++;
    if (pulses !== base + 1 || last_code !== 4'h1) begin
      errors++; $display("FAIL reaccept1: got pulses=%0d code=%h want 1/1", pulses - base, last_code);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (num !== 24'hAAAAA1) begin errors++; $display("FAIL reaccept1_num: got %h want aaaaa1", num); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("rst_release");
    rst = 1'b0;
    base = pulses;
    wait_pulse(base, 12 * SD);
    checks++;
    if (pulses !== base + 1) begin errors++; $display("FAIL reaccept2: got %0d want 1", pulses - base); end
    ka_en = 1'b0;
    wait_ticks(8);
    checks++;
    if (num !== 24'hAAAAA1 || pulses !== base + 1) begin
      errors++; $display("FAIL reaccept2_num: got num=%h pulses=%0d want aaaaa1/1", num, pulses - base);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_edit();
    test_bounce();
    test_hash_multi();
    test_reset_midop();
    checks++;
    if (wide !== 0) begin errors++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
